// File: rtl/i2c_slave_burst.sv
// I2C target with a 7-bit address filter, an internal register pointer and
// auto-incrementing burst reads/writes. SCL/SDA are oversampled on clk, so any
// SCL rate up to clk/16 works. SDA is only ever pulled low or released.
module i2c_slave_burst #(
    parameter logic [6:0]  DEV_ADDR  = 7'h50,
    parameter int unsigned MEM_DEPTH = 128,
    parameter int unsigned PTR_W     = $clog2(MEM_DEPTH),
    parameter int unsigned HOLD_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] wr_cnt
);

    localparam int unsigned HoldW = $clog2(HOLD_CYC + 1);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StIgnore,
        StWaitStop
    } state_e;

    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    state_e           state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic [7:0]       wr_cnt_q, wr_cnt_d;
    logic             oe_q, oe_d;
    logic             pend_q, pend_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [7:0]       mem_q [MEM_DEPTH];
    logic             mem_we;

    logic       scl_rise, scl_fall, start_det, stop_det, rd_phase, drv_slot;
    logic [7:0] byte_in;

    // Synchronisers run through reset so a bus caught mid-byte at reset release
    // cannot fake a START or STOP.
    always_ff @(posedge clk) begin
        scl_meta_q <= scl;
        scl_sync_q <= scl_meta_q;
        scl_prev_q <= scl_sync_q;
        sda_meta_q <= sda;
        sda_sync_q <= sda_meta_q;
        sda_prev_q <= sda_sync_q;
    end

    assign scl_rise  = scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q & scl_prev_q;
    assign start_det = scl_sync_q & sda_prev_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & ~sda_prev_q & sda_sync_q;
    assign rd_phase  = (state_q == StRdData) || (state_q == StRdAck);
    assign byte_in   = {shreg_q[6:0], sda_sync_q};

    // Level to present on SDA for the bit slot that begins at this SCL fall.
    always_comb begin
        drv_slot = 1'b0;
        case (state_q)
            StAddrAck, StPtrAck, StWrAck: drv_slot = 1'b1;
            StRdData:                     drv_slot = ~shreg_q[7];
            default:                      drv_slot = 1'b0;
        endcase
    end

    // Protocol FSM: bits are taken on SCL rise; START/STOP win over everything.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        wr_cnt_d  = wr_cnt_q;
        mem_we    = 1'b0;
        if (start_det) begin
            state_d   = StAddr;
            bitcnt_d  = '0;
            // A repeated START that cuts a read short still counts as an error.
            ack_err_d = rd_phase;
        end else if (stop_det) begin
            state_d = StIdle;
            done_d  = busy_q;
            busy_d  = 1'b0;
            if (rd_phase) begin
                ack_err_d = 1'b1;
            end
        end else if (scl_rise) begin
            case (state_q)
                StAddr: begin
                    shreg_d  = byte_in;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if (byte_in[7:1] == DEV_ADDR) begin
                            state_d = StAddrAck;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = StIgnore;
                            busy_d  = 1'b0;
                        end
                    end
                end
                StAddrAck: begin
                    bitcnt_d = '0;
                    if (shreg_q[0]) begin
                        state_d = StRdData;
                        shreg_d = mem_q[ptr_q];
                    end else begin
                        state_d = StPtr;
                    end
                end
                StPtr: begin
                    shreg_d  = byte_in;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        ptr_d    = byte_in[PTR_W-1:0];
                        wr_cnt_d = '0;
                        state_d  = StPtrAck;
                    end
                end
                StPtrAck, StWrAck: begin
                    bitcnt_d = '0;
                    state_d  = StWrData;
                end
                StWrData: begin
                    shreg_d  = byte_in;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        mem_we  = 1'b1;
                        ptr_d   = ptr_q + PTR_W'(1);
                        state_d = StWrAck;
                        if (wr_cnt_q != 8'hFF) begin
                            wr_cnt_d = wr_cnt_q + 8'd1;
                        end
                    end
                end
                StRdData: begin
                    shreg_d  = {shreg_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        ptr_d   = ptr_q + PTR_W'(1);
                        state_d = StRdAck;
                    end
                end
                StRdAck: begin
                    bitcnt_d = '0;
                    if (!sda_sync_q) begin
                        shreg_d = mem_q[ptr_q];
                        state_d = StRdData;
                    end else begin
                        state_d = StWaitStop;
                    end
                end
                default: ;
            endcase
        end
    end

    // SDA output: the slot level is latched at SCL fall and applied HOLD_CYC later.
    always_comb begin
        oe_d   = oe_q;
        pend_d = pend_q;
        hold_d = hold_q;
        if (start_det || stop_det) begin
            oe_d   = 1'b0;
            hold_d = '0;
        end else if (scl_fall) begin
            pend_d = drv_slot;
            hold_d = HoldW'(HOLD_CYC);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HoldW'(1);
            if (hold_q == HoldW'(1)) begin
                oe_d = pend_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            wr_cnt_q  <= '0;
            oe_q      <= 1'b0;
            pend_q    <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            wr_cnt_q  <= wr_cnt_d;
            oe_q      <= oe_d;
            pend_q    <= pend_d;
            hold_q    <= hold_d;
        end
    end

    // Register file; reset restores the identity pattern mem[i] = i.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= 8'(i);
            end
        end else if (mem_we) begin
            mem_q[ptr_q] <= byte_in;
        end
    end

    assign sda     = oe_q ? 1'b0 : 1'bz;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_i2c_slave_burst.sv
// Bench for i2c_slave_burst: bit-banged I2C master (SCL period 16 clk), memory
// model feeding a read-data scoreboard, and a bus monitor for SDA timing.
module tb_i2c_slave_burst;

    localparam int unsigned ExpDly = 3 + 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;  // 1 = master releases SDA
    wire        sda;
    logic       busy, done, ack_err;
    logic [7:0] wr_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0]  model_mem [128];
    int unsigned mptr = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];

    pullup (sda);
    assign sda = sda_m ? 1'bz : 1'b0;

    i2c_slave_burst dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl_m),
        .sda     (sda),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .wr_cnt  (wr_cnt)
    );

    always #5 clk = ~clk;

    // Bus monitor, sampled on the falling clk edge.
    int unsigned cyc = 0;
    int unsigned fall_cyc = 0;
    int          done_cnt = 0;
    int          tgt_low_cnt = 0;
    int          high_chg_cnt = 0;
    int unsigned delta_q[$];
    logic        scl_prev_n = 1'b1;
    logic        sda_prev_n = 1'b1;
    logic        m_prev_n = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (scl_prev_n && !scl_m) fall_cyc <= cyc;
            if (done === 1'b1) done_cnt <= done_cnt + 1;
            if (sda_m && sda === 1'b0) tgt_low_cnt <= tgt_low_cnt + 1;
            // Only changes the master cannot have caused are attributed to the target.
            if (sda_m && m_prev_n && (sda !== sda_prev_n)) begin
                if (scl_m && scl_prev_n) high_chg_cnt <= high_chg_cnt + 1;
                else delta_q.push_back(cyc - fall_cyc);
            end
        end
        scl_prev_n <= scl_m;
        sda_prev_n <= sda;
        m_prev_n   <= sda_m;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        if (!scl_m) begin
            clk_wait(4); sda_m = 1'b1;
            clk_wait(4); scl_m = 1'b1;
        end
        clk_wait(4); sda_m = 1'b0;
        clk_wait(4); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        clk_wait(4); sda_m = 1'b0;
        clk_wait(4); scl_m = 1'b1;
        clk_wait(4); sda_m = 1'b1;
        clk_wait(4);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        clk_wait(4); sda_m = b;
        clk_wait(4); scl_m = 1'b1;
        clk_wait(4); r = sda;
        clk_wait(4); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, r);
            d[i] = r;
        end
        bus_bit(~m_ack, r);
    endtask

    // Master ACKs every byte but the last.
    task automatic read_burst(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, b);
            got_q.push_back(b);
        end
    endtask

    task automatic sb_push(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_mem[mptr]);
            mptr = (mptr + 1) % 128;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) model_mem[i] = 8'(i);
        mptr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk_wait(5);
        rst = 1'b0;
        clk_wait(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL rst_ack_err: got %b want 0", ack_err); end
        checks++; if (wr_cnt !== 8'h00) begin errors++; $display("FAIL rst_wr_cnt: got %h want 00", wr_cnt); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rst_sda: got %b want 1", sda); end
    endtask

    task automatic test_write_burst();
        logic a;
        logic [7:0] data [3];
        logic [7:0] e, g;
        int d0;
        data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
        d0 = done_cnt;
        bus_start();
        write_byte(8'hA0, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b want 0", a); end
        write_byte(8'h10, a);
        mptr = 'h10;
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_ptr_ack: got %b want 0", a); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy); end
        for (int i = 0; i < 3; i++) begin
            write_byte(data[i], a);
            model_mem[mptr] = data[i];
            mptr = (mptr + 1) % 128;
            checks++; if (a !== 1'b0) begin errors++; $display("FAIL wr_data_ack%0d: got %b want 0", i, a); end
        end
        bus_stop();
        clk_wait(4);
        checks++; if (wr_cnt !== 8'd3) begin errors++; $display("FAIL wr_cnt: got %0d want 3", wr_cnt); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL wr_done: got %0d pulses want 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %b want 0", busy); end
        // Read the burst back.
        bus_start();
        write_byte(8'hA0, a);
        write_byte(8'h10, a);
        mptr = 'h10;
        bus_start();
        write_byte(8'hA1, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rb_addr_ack: got %b want 0", a); end
        sb_push(3);
        read_burst(3);
        bus_stop();
        while (got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL wr_readback: got %h want %h", g, e); end
        end
    endtask

    task automatic test_combined_read();
        logic a0, a1, a2;
        logic [7:0] e, g;
        bus_start();
        write_byte(8'hA0, a0);
        write_byte(8'h7E, a1);
        mptr = 'h7E;
        bus_start();
        write_byte(8'hA1, a2);
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL cr_acks: got %b want 000", {a0, a1, a2}); end
        sb_push(3);
        read_burst(3);
        bus_stop();
        clk_wait(4);
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL cr_ack_err: got %b want 0", ack_err); end
        // Pointer must have wrapped to 0x01; a plain read shows it.
        bus_start();
        write_byte(8'hA1, a0);
        checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL cr_addr2_ack: got %b want 0", a0); end
        sb_push(1);
        read_burst(1);
        bus_stop();
        while (got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL cr_data: got %h want %h", g, e); end
        end
    endtask

    task automatic test_addr_mismatch();
        logic a;
        int d0, l0;
        d0 = done_cnt;
        l0 = tgt_low_cnt;
        bus_start();
        write_byte(8'hA2, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL mm_addr_nack: got %b want 1", a); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mm_busy: got %b want 0", busy); end
        write_byte(8'h55, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL mm_data_nack: got %b want 1", a); end
        bus_stop();
        clk_wait(4);
        checks++; if (tgt_low_cnt !== l0) begin errors++; $display("FAIL mm_sda_low: got %0d low samples want 0", tgt_low_cnt - l0); end
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL mm_done: got %0d pulses want 0", done_cnt - d0); end
    endtask

    task automatic test_read_no_nack();
        logic a;
        logic [7:0] b, e;
        bus_start();
        write_byte(8'hA0, a);
        write_byte(8'h20, a);
        mptr = 'h20;
        write_byte(8'h5A, a);
        model_mem[mptr] = 8'h5A; mptr = (mptr + 1) % 128;
        write_byte(8'hC3, a);
        model_mem[mptr] = 8'hC3; mptr = (mptr + 1) % 128;
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rn_wr_ack: got %b want 0", a); end
        bus_stop();
        bus_start();
        write_byte(8'hA0, a);
        write_byte(8'h20, a);
        mptr = 'h20;
        bus_start();
        write_byte(8'hA1, a);
        sb_push(1);
        // ACK the byte, then STOP while the target is sending 0xC3 (MSB released).
        read_byte(1'b1, b);
        bus_stop();
        clk_wait(4);
        e = exp_q.pop_front();
        checks++; if (b !== e) begin errors++; $display("FAIL rn_data: got %h want %h", b, e); end
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL rn_ack_err_set: got %b want 1", ack_err); end
        bus_start();
        clk_wait(2);
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL rn_ack_err_clr: got %b want 0", ack_err); end
        bus_stop();
    endtask

    task automatic test_reset_mid();
        logic a, r;
        logic [7:0] e, g;
        int d0;
        bus_start();
        write_byte(8'hA0, a);
        write_byte(8'h10, a);
        write_byte(8'h99, a);
        clk_wait(4);
        checks++; if (wr_cnt !== 8'd1) begin errors++; $display("FAIL rm_wr_cnt_pre: got %0d want 1", wr_cnt); end
        // Second data byte 0xF0: three bits, then reset while SCL is high on the 4th.
        for (int i = 0; i < 3; i++) bus_bit(1'b1, r);
        clk_wait(4); sda_m = 1'b1;
        clk_wait(4); scl_m = 1'b1;
        clk_wait(2);
        rst = 1'b1;
        clk_wait(1);
        rst = 1'b0;
        model_reset();
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rm_sda: got %b want 1", sda); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
        checks++; if (wr_cnt !== 8'd0) begin errors++; $display("FAIL rm_wr_cnt: got %0d want 0", wr_cnt); end
        clk_wait(5); scl_m = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) bus_bit(1'b0, r);
        bus_bit(1'b1, r);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL rm_no_ack: got %b want 1", r); end
        write_byte(8'h77, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL rm_ignored: got %b want 1", a); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy2: got %b want 0", busy); end
        bus_stop();
        clk_wait(4);
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rm_done: got %0d pulses want 0", done_cnt - d0); end
        // Memory must be back to identity.
        bus_start();
        write_byte(8'hA0, a);
        write_byte(8'h10, a);
        mptr = 'h10;
        bus_start();
        write_byte(8'hA1, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rm_addr_ack: got %b want 0", a); end
        sb_push(3);
        read_burst(3);
        bus_stop();
        while (got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL rm_readback: got %h want %h", g, e); end
        end
    endtask

    task automatic test_timing();
        int unsigned d;
        checks++;
        if (delta_q.size() < 10) begin
            errors++;
            $display("FAIL tim_samples: got %0d target SDA changes want >= 10", delta_q.size());
        end
        while (delta_q.size() > 0) begin
            d = delta_q.pop_front();
            checks++;
            if (d !== ExpDly) begin
                errors++;
                $display("FAIL tim_delay: got %0d clk after SCL fall want %0d", d, ExpDly);
            end
        end
        checks++;
        if (high_chg_cnt !== 0) begin
            errors++;
            $display("FAIL tim_scl_high: got %0d changes while SCL high want 0", high_chg_cnt);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_burst();
        test_combined_read();
        test_addr_mismatch();
        test_read_no_nack();
        test_reset_mid();
        test_timing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
